// File: rtl/ecc_secded_enc_pipe_if.sv
// Valid/ready stream and injection-control bundle for the SECDED encoder.
// Codeword width is derived from DATA_WIDTH exactly as the encoder does.
interface ecc_secded_enc_pipe_if #(
    parameter int DATA_WIDTH = 33
);
    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    localparam int R = calc_r(DATA_WIDTH);
    localparam int N = DATA_WIDTH + R + 1;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_injected;
    logic                  inj_req;
    logic [1:0]            inj_mode;
    logic [6:0]            inj_pos;
    logic                  inj_bad_pos;
    logic [31:0]           word_count;

    modport master (
        output in_data, in_valid, out_ready, inj_req, inj_mode, inj_pos,
        input  in_ready, out_data, out_valid, out_injected, inj_bad_pos,
        input  word_count
    );

    modport slave (
        input  in_data, in_valid, out_ready, inj_req, inj_mode, inj_pos,
        output in_ready, out_data, out_valid, out_injected, inj_bad_pos,
        output word_count
    );
endinterface

// File: rtl/ecc_secded_enc_pipe.sv
// Flow-controlled SECDED encoder pipeline with one-shot error injection.
// Whole pipe advances together; flips are applied entering the last stage.
module ecc_secded_enc_pipe #(
    parameter int DATA_WIDTH = 33,
    parameter int LATENCY    = 2,
    parameter bit PINVERT    = 1'b1
) (
    input  logic                clk,
    input  logic                arst_n,
    ecc_secded_enc_pipe_if.slave bus
);
    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    localparam int R = calc_r(DATA_WIDTH);
    localparam int N = DATA_WIDTH + R + 1;

    typedef struct packed {
        logic         vld;
        logic [1:0]   mode;
        logic [6:0]   pos;
        logic [N-1:0] cw;
    } stage_t;

    function automatic logic [N-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [N-1:0] cw;
        logic         p;
        int           j;
        cw = '0;
        j  = 0;
        for (int i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j = j + 1;
            end
        end
        for (int k = 0; k < R; k++) begin
            p = 1'b0;
            for (int i = 1; i < N; i++) begin
                if (((i >> k) & 1) == 1 && (i & (i - 1)) != 0) p = p ^ cw[i];
            end
            cw[1 << k] = p;
        end
        // bit 0 is still zero here, so this is parity of all other bits
        cw[0] = ^cw;
        if (PINVERT) begin
            cw[0] = ~cw[0];
            for (int k = 0; k < R; k++) cw[1 << k] = ~cw[1 << k];
        end
        return cw;
    endfunction

    function automatic stage_t inject(input stage_t s);
        stage_t r;
        int     p;
        int     p2;
        r  = s;
        p  = int'(s.pos);
        p2 = (p + 1 == N) ? 0 : p + 1;
        if (p >= N) begin
            r.mode = 2'b00;
        end else if (s.mode == 2'b01) begin
            r.cw[p] = ~s.cw[p];
        end else if (s.mode == 2'b10) begin
            r.cw[p]  = ~s.cw[p];
            r.cw[p2] = ~s.cw[p2];
        end
        return r;
    endfunction

    logic [1:0]  rsync_q;
    logic        rst_n;
    stage_t      stg_q [LATENCY];
    stage_t      stg_d [LATENCY];
    logic        armed_q, armed_d;
    logic [1:0]  amode_q, amode_d;
    logic [6:0]  apos_q, apos_d;
    logic        bad_q, bad_d;
    logic [31:0] cnt_q, cnt_d;
    logic        adv;
    logic        accept;
    logic        req_ok;
    logic [1:0]  eff_mode;
    logic [6:0]  eff_pos;

    // Reset asserts immediately, releases two clocks later in this domain
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rsync_q <= 2'b00;
        else         rsync_q <= {rsync_q[0], 1'b1};
    end

    assign rst_n = rsync_q[1];

    assign bus.out_data     = stg_q[LATENCY-1].cw;
    assign bus.out_valid    = stg_q[LATENCY-1].vld;
    assign bus.out_injected = |stg_q[LATENCY-1].mode;
    assign bus.in_ready     = bus.out_ready | ~bus.out_valid;
    assign bus.inj_bad_pos  = bad_q;
    assign bus.word_count   = cnt_q;

    // Next state: arming, stage shift with final-stage injection, counter
    always_comb begin
        stg_d    = stg_q;
        armed_d  = armed_q;
        amode_d  = amode_q;
        apos_d   = apos_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        adv      = bus.in_ready;
        accept   = bus.in_valid & bus.in_ready;
        req_ok   = bus.inj_req &
                   (bus.inj_mode == 2'b01 || bus.inj_mode == 2'b10);
        eff_mode = req_ok ? bus.inj_mode : (armed_q ? amode_q : 2'b00);
        eff_pos  = req_ok ? bus.inj_pos : apos_q;
        if (req_ok) begin
            armed_d = 1'b1;
            amode_d = bus.inj_mode;
            apos_d  = bus.inj_pos;
            if (int'(bus.inj_pos) >= N) bad_d = 1'b1;
        end
        if (accept) armed_d = 1'b0;
        if (adv) begin
            stg_d[0].vld  = bus.in_valid;
            stg_d[0].mode = accept ? eff_mode : 2'b00;
            stg_d[0].pos  = eff_pos;
            stg_d[0].cw   = encode(bus.in_data);
            for (int i = 1; i < LATENCY; i++) stg_d[i] = stg_q[i-1];
            stg_d[LATENCY-1] = inject(stg_d[LATENCY-1]);
        end
        if (bus.out_valid && bus.out_ready) cnt_d = cnt_q + 32'd1;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
            armed_q <= 1'b0;
            amode_q <= 2'b00;
            apos_q  <= 7'd0;
            bad_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            for (int i = 0; i < LATENCY; i++) stg_q[i] <= stg_d[i];
            armed_q <= armed_d;
            amode_q <= amode_d;
            apos_q  <= apos_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ecc_secded_enc_pipe.sv
// Directed bench: 33-bit/LAT2/no-invert and 8-bit/LAT4/inverted encoders.
// Expected codewords are hand-derived; random words are checked by syndrome.
module tb_ecc_secded_enc_pipe;
    logic clk = 1'b0;
    logic arst_a;
    logic arst_b;
    int   errs   = 0;
    int   checks = 0;

    ecc_secded_enc_pipe_if #(.DATA_WIDTH(33)) ifa ();
    ecc_secded_enc_pipe_if #(.DATA_WIDTH(8))  ifb ();

    ecc_secded_enc_pipe #(
        .DATA_WIDTH(33), .LATENCY(2), .PINVERT(1'b0)
    ) dut_a (
        .clk(clk), .arst_n(arst_a), .bus(ifa.slave)
    );

    ecc_secded_enc_pipe #(
        .DATA_WIDTH(8), .LATENCY(4), .PINVERT(1'b1)
    ) dut_b (
        .clk(clk), .arst_n(arst_b), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] dec_a(input logic [39:0] cw);
        logic [32:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < 40; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic syn_ok_a(input logic [39:0] cw,
                                      input logic [32:0] d);
        int   syn;
        logic par;
        syn = 0;
        par = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cw[i]) begin
                syn = syn ^ i;
                par = ~par;
            end
        end
        return (syn == 0) && (par == 1'b0) && (dec_a(cw) == d);
    endfunction

    task automatic xfer_a(input logic [32:0] d, input logic req,
                          input logic [1:0] md, input logic [6:0] ps,
                          output logic [39:0] cw, output logic inj,
                          output int lat);
        @(negedge clk);
        ifa.in_data   = d;
        ifa.in_valid  = 1'b1;
        ifa.out_ready = 1'b1;
        ifa.inj_req   = req;
        ifa.inj_mode  = md;
        ifa.inj_pos   = ps;
        @(negedge clk);
        lat = 1;
        ifa.in_valid = 1'b0;
        ifa.inj_req  = 1'b0;
        while (!ifa.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        cw  = ifa.out_data;
        inj = ifa.out_injected;
    endtask

    task automatic xfer_b(input logic [7:0] d, output logic [12:0] cw,
                          output int lat);
        @(negedge clk);
        ifb.in_data   = d;
        ifb.in_valid  = 1'b1;
        ifb.out_ready = 1'b1;
        @(negedge clk);
        lat = 1;
        ifb.in_valid = 1'b0;
        while (!ifb.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        cw = ifb.out_data;
    endtask

    task automatic arm_a(input logic [1:0] md, input logic [6:0] ps);
        @(negedge clk);
        ifa.inj_req  = 1'b1;
        ifa.inj_mode = md;
        ifa.inj_pos  = ps;
        @(negedge clk);
        ifa.inj_req = 1'b0;
    endtask

    task automatic reset_a();
        @(negedge clk);
        arst_a = 1'b0;
        repeat (2) @(negedge clk);
        arst_a = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [39:0] cw;
    logic [12:0] cwb;
    logic        inj;
    int          lat;
    logic [32:0] d;
    logic [32:0] sv [64];
    int          sent, rcv, cyc, seen;
    logic        prev_stall;
    logic [39:0] prev_cw;

    initial begin
        ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifa.inj_req = 1'b0; ifa.inj_mode = 2'b00; ifa.inj_pos = 7'd0;
        ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        ifb.inj_req = 1'b0; ifb.inj_mode = 2'b00; ifb.inj_pos = 7'd0;
        arst_a = 1'b0;
        arst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_out_data", 64'(ifa.out_data), 64'd0);
        chk("rst_out_injected", 64'(ifa.out_injected), 64'd0);
        chk("rst_bad_pos", 64'(ifa.inj_bad_pos), 64'd0);
        chk("rst_word_count", 64'(ifa.word_count), 64'd0);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(ifb.out_valid), 64'd0);
        arst_a = 1'b1;
        arst_b = 1'b1;
        repeat (4) @(negedge clk);

        xfer_a(33'h0, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("a_latency", 64'(lat), 64'd2);
        chk("a_zero", 64'(cw), 64'h0);
        xfer_a(33'h1, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("a_d0", 64'(cw), 64'h0F);
        xfer_a(33'h1_0000_0000, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("a_d32", 64'(cw), 64'h81_0000_0017);
        xfer_a(33'h2, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("a_d1", 64'(cw), 64'h33);
        chk("a_d1_injected", 64'(inj), 64'd0);
        for (int i = 0; i < 16; i++) begin
            d = 33'({$urandom, $urandom});
            xfer_a(d, 1'b0, 2'b00, 7'd0, cw, inj, lat);
            chk("a_rand_syndrome", 64'(syn_ok_a(cw, d)), 64'd1);
        end
        @(negedge clk);
        chk("a_word_count_20", 64'(ifa.word_count), 64'd20);

        xfer_a(33'h0, 1'b1, 2'b01, 7'd5, cw, inj, lat);
        chk("inj_single_data", 64'(cw), 64'h20);
        chk("inj_single_flag", 64'(inj), 64'd1);
        xfer_a(33'h0, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("inj_next_clean", 64'(cw), 64'h0);
        chk("inj_next_flag", 64'(inj), 64'd0);
        xfer_a(33'h1, 1'b1, 2'b10, 7'd39, cw, inj, lat);
        chk("inj_double_wrap", 64'(cw), 64'h80_0000_000E);
        chk("inj_double_flag", 64'(inj), 64'd1);
        arm_a(2'b01, 7'd2);
        xfer_a(33'h0, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("inj_armed_later", 64'(cw), 64'h04);
        chk("inj_armed_flag", 64'(inj), 64'd1);
        xfer_a(33'h0, 1'b1, 2'b11, 7'd3, cw, inj, lat);
        chk("inj_mode11", 64'(cw), 64'h0);
        chk("inj_mode11_flag", 64'(inj), 64'd0);
        chk("bad_pos_before", 64'(ifa.inj_bad_pos), 64'd0);
        xfer_a(33'h1, 1'b1, 2'b01, 7'd45, cw, inj, lat);
        chk("bad_pos_data", 64'(cw), 64'h0F);
        chk("bad_pos_flag", 64'(inj), 64'd0);
        chk("bad_pos_set", 64'(ifa.inj_bad_pos), 64'd1);
        xfer_a(33'h0, 1'b0, 2'b00, 7'd0, cw, inj, lat);
        chk("bad_pos_sticky", 64'(ifa.inj_bad_pos), 64'd1);
        reset_a();
        chk("bad_pos_reset", 64'(ifa.inj_bad_pos), 64'd0);
        chk("a_word_count_reset", 64'(ifa.word_count), 64'd0);

        for (int i = 0; i < 64; i++) begin
            sv[i] = {i[0], 32'(i * 32'h9E37_79B1)};
        end
        sent = 0;
        rcv = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_cw = '0;
        while (rcv < 64 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) chk("stall_hold", 64'(ifa.out_data), 64'(prev_cw));
            ifa.out_ready = ($urandom % 3) != 0;
            ifa.in_valid  = sent < 64;
            ifa.in_data   = sv[sent < 64 ? sent : 0];
            #1;
            if (ifa.out_valid && ifa.out_ready) begin
                chk("stream_order", 64'(dec_a(ifa.out_data)), 64'(sv[rcv]));
                chk("stream_syndrome",
                    64'(syn_ok_a(ifa.out_data, sv[rcv])), 64'd1);
                rcv++;
            end
            if (ifa.out_valid && !ifa.out_ready)
                chk("stall_in_ready", 64'(ifa.in_ready), 64'd0);
            if (ifa.in_valid && ifa.in_ready) sent++;
            prev_stall = ifa.out_valid && !ifa.out_ready;
            prev_cw = ifa.out_data;
        end
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("stream_received", 64'(rcv), 64'd64);
        chk("stream_word_count", 64'(ifa.word_count), 64'd64);
        chk("stream_drained", 64'(ifa.out_valid), 64'd0);

        xfer_b(8'h00, cwb, lat);
        chk("b_latency", 64'(lat), 64'd4);
        chk("b_zero_inverted", 64'(cwb), 64'h117);
        xfer_b(8'h01, cwb, lat);
        chk("b_d0", 64'(cwb), 64'h118);
        xfer_b(8'hFF, cwb, lat);
        chk("b_ones", 64'(cwb), 64'h1FF9);
        @(negedge clk);
        chk("b_word_count", 64'(ifb.word_count), 64'd3);

        ifb.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifb.in_data  = 8'(i + 5);
            ifb.in_valid = 1'b1;
        end
        @(negedge clk);
        ifb.in_valid = 1'b0;
        chk("b_midstream_none_out", 64'(ifb.out_valid), 64'd0);
        arst_b = 1'b0;
        repeat (2) @(negedge clk);
        arst_b = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifb.out_valid) seen++;
        end
        chk("b_reset_drops", 64'(seen), 64'd0);
        chk("b_reset_count", 64'(ifb.word_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
